// File: rtl/ship_pkg.sv
// Shared types and constants for the ship motion controller: FSM states,
// fixed-point widths, start position and the heading-to-direction table.
package ship_pkg;

    localparam int POS_W = 14;
    localparam int VEL_W = 8;
    localparam int FRAC  = 4;

    localparam int START_X = 144;
    localparam int START_Y = 104;

    localparam logic [5:0] DIR_RESET = 6'b000111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROTATE = 3'd1,
        ST_VEL    = 3'd2,
        ST_POS    = 3'd3,
        ST_DRAW   = 3'd4
    } ship_state_t;

    // Direction code {x_left, x_mag[1:0], y_up, y_mag[1:0]}, heading 0 = up, clockwise.
    localparam logic [5:0] HEADING_LUT [16] = '{
        6'b000111, 6'b001111, 6'b011111, 6'b011101,
        6'b011100, 6'b011001, 6'b011011, 6'b001011,
        6'b000011, 6'b101011, 6'b111011, 6'b111001,
        6'b111100, 6'b111101, 6'b111111, 6'b101111
    };

    function automatic logic [5:0] heading_code(input logic [3:0] heading);
        return HEADING_LUT[heading];
    endfunction

endpackage

// File: rtl/ship_axis_integrator.sv
// One axis of ship motion: velocity accelerate/saturate/friction decay and
// 10.4 fixed-point position integration with wrap at the screen extent.
module ship_axis_integrator
    import ship_pkg::*;
#(
    parameter int EXTENT = 320,
    parameter int START  = 144,
    parameter int VMAX   = 48
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    vel_en,
    input  logic                    pos_en,
    input  logic                    accel,
    input  logic                    decay,
    input  logic                    neg,
    input  logic [1:0]              mag,
    output logic [POS_W-FRAC-1:0]   pix
);

    localparam logic [POS_W-1:0]        POS_RST = POS_W'(START * 16);
    localparam logic signed [POS_W:0]   WRAP_S  = (POS_W+1)'(EXTENT * 16);
    localparam logic signed [VEL_W:0]   VMAX_S  = (VEL_W+1)'(VMAX);

    logic [POS_W-1:0]        pos;
    logic [VEL_W-1:0]        vel;
    logic signed [VEL_W:0]   vel_ext;
    logic signed [VEL_W:0]   mag_ext;
    logic signed [VEL_W:0]   delta;
    logic signed [VEL_W:0]   vel_sum;
    logic [VEL_W-1:0]        vel_sat;
    logic [VEL_W-1:0]        vel_dec;
    logic signed [POS_W:0]   pos_sum;
    logic signed [POS_W:0]   pos_wrap;
    logic [POS_W-1:0]        pos_next;

    always_comb begin
        vel_ext = {vel[VEL_W-1], vel};
        mag_ext = {{(VEL_W-1){1'b0}}, mag};
        delta   = neg ? -mag_ext : mag_ext;
        vel_sum = vel_ext + delta;
        if (vel_sum > VMAX_S) begin
            vel_sat = VMAX_S[VEL_W-1:0];
        end else if (vel_sum < -VMAX_S) begin
            vel_sat = vel_sat_neg();
        end else begin
            vel_sat = vel_sum[VEL_W-1:0];
        end

        // Friction moves one unit toward zero; zero stays put.
        if (vel[VEL_W-1]) begin
            vel_dec = vel + 1'b1;
        end else if (vel != '0) begin
            vel_dec = vel - 1'b1;
        end else begin
            vel_dec = '0;
        end
    end

    function automatic logic [VEL_W-1:0] vel_sat_neg();
        logic signed [VEL_W:0] n;
        n = -VMAX_S;
        return n[VEL_W-1:0];
    endfunction

    always_comb begin
        pos_sum = $signed({1'b0, pos}) + $signed({{(POS_W+1-VEL_W){vel[VEL_W-1]}}, vel});
        if (pos_sum[POS_W]) begin
            pos_wrap = pos_sum + WRAP_S;
        end else if (pos_sum >= WRAP_S) begin
            pos_wrap = pos_sum - WRAP_S;
        end else begin
            pos_wrap = pos_sum;
        end
        pos_next = pos_wrap[POS_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos <= POS_RST;
            vel <= '0;
        end else begin
            if (vel_en) begin
                if (accel) begin
                    vel <= vel_sat;
                end else if (decay) begin
                    vel <= vel_dec;
                end
            end
            if (pos_en) begin
                pos <= pos_next;
            end
        end
    end

    assign pix = pos[POS_W-1:FRAC];

endmodule

// File: rtl/ship_motion_ctrl.sv
// Per-frame ship update (rotate, velocity, position) followed by a fixed
// draw window during which position and direction are held for the drawer.
module ship_motion_ctrl
    import ship_pkg::*;
#(
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240,
    parameter int VMAX         = 48,
    parameter int FRICTION_DIV = 4,
    parameter int DRAW_CYCLES  = 2112
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       rot_left,
    input  logic       rot_right,
    input  logic       thrust,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [5:0] direction,
    output logic       plot,
    output logic       busy
);

    localparam int CNT_W = $clog2(DRAW_CYCLES);
    localparam int FC_W  = $clog2(FRICTION_DIV + 1);

    ship_state_t       state;
    ship_state_t       state_next;
    logic [CNT_W-1:0]  draw_cnt;
    logic [FC_W-1:0]   fric_cnt;
    logic [3:0]        heading;
    logic [3:0]        heading_next;
    logic              rl_q;
    logic              rr_q;
    logic              th_q;
    logic              fric_hit;
    logic              vel_en;
    logic              pos_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            draw_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_POS) begin
                draw_cnt <= CNT_W'(DRAW_CYCLES - 1);
            end else if (state == ST_DRAW && draw_cnt != '0) begin
                draw_cnt <= draw_cnt - 1'b1;
            end
        end
    end

    // frame_tick is only looked at in IDLE; ticks during an update or draw are dropped.
    always_comb begin
        state_next = state;
        plot       = 1'b0;
        busy       = 1'b1;
        vel_en     = 1'b0;
        pos_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (frame_tick) begin
                    state_next = ST_ROTATE;
                end
            end
            ST_ROTATE: state_next = ST_VEL;
            ST_VEL: begin
                vel_en     = 1'b1;
                state_next = ST_POS;
            end
            ST_POS: begin
                pos_en     = 1'b1;
                state_next = ST_DRAW;
            end
            ST_DRAW: begin
                plot = 1'b1;
                if (draw_cnt == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        heading_next = heading;
        if (rr_q && !rl_q) begin
            heading_next = heading + 4'd1;
        end else if (rl_q && !rr_q) begin
            heading_next = heading - 4'd1;
        end
        fric_hit = !th_q && (fric_cnt == FC_W'(FRICTION_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rl_q      <= 1'b0;
            rr_q      <= 1'b0;
            th_q      <= 1'b0;
            heading   <= 4'd0;
            direction <= DIR_RESET;
            fric_cnt  <= '0;
        end else begin
            if (state == ST_IDLE && frame_tick) begin
                rl_q <= rot_left;
                rr_q <= rot_right;
                th_q <= thrust;
            end
            if (state == ST_ROTATE) begin
                heading   <= heading_next;
                direction <= heading_code(heading_next);
            end
            if (state == ST_VEL) begin
                if (th_q || fric_hit) begin
                    fric_cnt <= '0;
                end else begin
                    fric_cnt <= fric_cnt + 1'b1;
                end
            end
        end
    end

    ship_axis_integrator #(
        .EXTENT (SCREEN_W),
        .START  (START_X),
        .VMAX   (VMAX)
    ) u_axis_x (
        .clk     (clk),
        .reset_n (reset_n),
        .vel_en  (vel_en),
        .pos_en  (pos_en),
        .accel   (th_q),
        .decay   (fric_hit),
        .neg     (direction[5]),
        .mag     (direction[4:3]),
        .pix     (x_pos)
    );

    ship_axis_integrator #(
        .EXTENT (SCREEN_H),
        .START  (START_Y),
        .VMAX   (VMAX)
    ) u_axis_y (
        .clk     (clk),
        .reset_n (reset_n),
        .vel_en  (vel_en),
        .pos_en  (pos_en),
        .accel   (th_q),
        .decay   (fric_hit),
        .neg     (direction[2]),
        .mag     (direction[1:0]),
        .pix     (y_pos)
    );

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Bench for ship_motion_ctrl: a full-length instance for draw-window timing
// and reset abort, a short-window instance for long multi-frame motion runs.
module tb_ship_motion_ctrl;

    localparam int FULL_DRAW = 2112;
    localparam int FAST_DRAW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n   = 1'b0;
    logic tick      = 1'b0;
    logic rot_left  = 1'b0;
    logic rot_right = 1'b0;
    logic thrust    = 1'b0;
    logic use_fast  = 1'b0;

    logic       tick_a, tick_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [5:0] dir_a, dir_b;
    logic       plot_a, plot_b, busy_a, busy_b;

    assign tick_a = tick & ~use_fast;
    assign tick_b = tick & use_fast;

    ship_motion_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .frame_tick(tick_a),
        .rot_left(rot_left), .rot_right(rot_right), .thrust(thrust),
        .x_pos(x_a), .y_pos(y_a), .direction(dir_a), .plot(plot_a), .busy(busy_a)
    );

    ship_motion_ctrl #(.DRAW_CYCLES(FAST_DRAW)) dut_b (
        .clk(clk), .reset_n(reset_n), .frame_tick(tick_b),
        .rot_left(rot_left), .rot_right(rot_right), .thrust(thrust),
        .x_pos(x_b), .y_pos(y_b), .direction(dir_b), .plot(plot_b), .busy(busy_b)
    );

    logic [9:0] c_x, c_y;
    logic [5:0] c_dir;
    logic       c_plot, c_busy;
    assign c_x    = use_fast ? x_b    : x_a;
    assign c_y    = use_fast ? y_b    : y_a;
    assign c_dir  = use_fast ? dir_b  : dir_a;
    assign c_plot = use_fast ? plot_b : plot_a;
    assign c_busy = use_fast ? busy_b : busy_a;

    logic [5:0] lut [16] = '{
        6'b000111, 6'b001111, 6'b011111, 6'b011101,
        6'b011100, 6'b011001, 6'b011011, 6'b001011,
        6'b000011, 6'b101011, 6'b111011, 6'b111001,
        6'b111100, 6'b111101, 6'b111111, 6'b101111
    };

    int m_head, m_vx, m_vy, m_px, m_py, m_fc;
    logic [25:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int obs_x, obs_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > 48) return 48;
        if (v < -48) return -48;
        return v;
    endfunction

    function automatic int toward0(input int v);
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_head = 0; m_vx = 0; m_vy = 0; m_fc = 0;
        m_px = 144 * 16; m_py = 104 * 16;
    endtask

    task automatic model_frame(input bit rl, input bit rr, input bit th);
        logic [5:0] d;
        int sx, sy, xm, ym;
        logic [9:0] ex, ey;
        if (rl != rr) m_head = rr ? (m_head + 1) % 16 : (m_head + 15) % 16;
        d  = lut[m_head];
        xm = int'(d[4:3]);
        ym = int'(d[1:0]);
        sx = d[5] ? -1 : 1;
        sy = d[2] ? -1 : 1;
        if (th) begin
            m_vx = clampv(m_vx + sx * xm);
            m_vy = clampv(m_vy + sy * ym);
            m_fc = 0;
        end else begin
            m_fc++;
            if (m_fc == 4) begin
                m_fc = 0;
                m_vx = toward0(m_vx);
                m_vy = toward0(m_vy);
            end
        end
        m_px += m_vx;
        if (m_px >= 320 * 16) m_px -= 320 * 16;
        if (m_px < 0) m_px += 320 * 16;
        m_py += m_vy;
        if (m_py >= 240 * 16) m_py -= 240 * 16;
        if (m_py < 0) m_py += 240 * 16;
        ex = 10'(m_px / 16);
        ey = 10'(m_py / 16);
        exp_q.push_back({ex, ey, d});
    endtask

    // One accepted frame; poke pulses frame_tick inside the draw window.
    task automatic run_frame(input bit rl, input bit rr, input bit th, input bit poke);
        logic [25:0] expv;
        int lat, w;
        @(negedge clk);
        rot_left = rl; rot_right = rr; thrust = th; tick = 1'b1;
        model_frame(rl, rr, th);
        @(negedge clk);
        tick = 1'b0;
        check("busy_rise", 32'(c_busy), 32'd1);
        lat = 1;
        while (!c_plot && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("plot_latency", lat, 32'd4);
        expv = exp_q.pop_front();
        check("frame_xydir", 32'({c_x, c_y, c_dir}), 32'(expv));
        obs_x = int'(c_x);
        obs_y = int'(c_y);
        w = 0;
        while (c_plot && w < 3000) begin
            tick = poke && (w == 5);
            w++;
            @(negedge clk);
        end
        tick = 1'b0;
        check("plot_width", w, use_fast ? FAST_DRAW : FULL_DRAW);
        check("busy_fall", 32'(c_busy), 32'd0);
        @(negedge clk);
        check("idle_after_draw", 32'({c_busy, c_plot}), 32'd0);
        check("hold_after_draw", 32'({c_x, c_y, c_dir}), 32'(expv));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; tick = 1'b0; rot_left = 1'b0; rot_right = 1'b0; thrust = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_plot_busy", 32'({c_plot, c_busy}), 32'd0);
        check("reset_xydir", 32'({c_x, c_y, c_dir}), 32'({10'd144, 10'd104, 6'b000111}));
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, y_prev, y19, x192, y192;
        bit saw_wrap;

        // Full-length draw window: idle frame, dropped tick, reset abort.
        use_fast = 1'b0;
        do_reset();
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 0, 1);
        run_frame(0, 1, 0, 0);
        check("dir_after_poke_frame", 32'(c_dir), 32'(6'b001111));

        @(negedge clk);
        rot_right = 1'b1; thrust = 1'b1; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat = 1;
        while (!c_plot && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("abort_frame_plot", 32'(c_plot), 32'd1);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_plot_busy", 32'({c_plot, c_busy}), 32'd0);
        check("abort_xydir", 32'({c_x, c_y, c_dir}), 32'({10'd144, 10'd104, 6'b000111}));
        reset_n = 1'b1; rot_right = 1'b0; thrust = 1'b0;
        model_reset();
        run_frame(0, 0, 0, 0);

        // Short draw window for long motion sequences.
        use_fast = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) run_frame(0, 1, 0, 0);
        check("dir_heading4", 32'(c_dir), 32'(6'b011100));
        for (int i = 0; i < 12; i++) run_frame(0, 1, 0, 0);
        check("dir_heading16", 32'(c_dir), 32'(6'b000111));
        run_frame(1, 1, 0, 0);
        run_frame(1, 1, 0, 0);
        check("dir_both_hold", 32'(c_dir), 32'(6'b000111));
        run_frame(1, 0, 0, 0);
        check("dir_rot_left", 32'(c_dir), 32'(6'b101111));
        run_frame(0, 1, 0, 0);
        check("dir_back_up", 32'(c_dir), 32'(6'b000111));

        saw_wrap = 1'b0;
        y_prev   = obs_y;
        y19      = 0;
        for (int i = 0; i < 45; i++) begin
            run_frame(0, 0, 1, 0);
            if (i == 19) y19 = obs_y;
            if (i == 20) check("y_step_saturated", y19 - obs_y, 32'd3);
            if (y_prev < 3 && obs_y >= 236) saw_wrap = 1'b1;
            y_prev = obs_y;
        end
        check("y_wrap_seen", 32'(saw_wrap), 32'd1);

        for (int i = 0; i < 4; i++) run_frame(0, 1, 0, 0);
        check("dir_heading4_again", 32'(c_dir), 32'(6'b011100));
        for (int i = 0; i < 16; i++) run_frame(0, 0, 1, 0);
        x192 = 0;
        y192 = 0;
        for (int i = 0; i < 194; i++) begin
            run_frame(0, 0, 0, 0);
            if (i == 191) begin
                x192 = obs_x;
                y192 = obs_y;
            end
        end
        check("x_stopped", obs_x, x192);
        check("y_stopped", obs_y, y192);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
